// File: rtl/bcd_pkg.sv
// Shared types and constants for the iterative binary-to-BCD sequencer.
package bcd_pkg;

   localparam int BCD_WIDTH  = 18;
   localparam int BCD_DIGITS = 6;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   function automatic logic [3:0] adj_const();
      return 4'd3;
   endfunction

   function automatic logic [3:0] adj_thresh();
      return 4'd5;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit slice: a digit of 5 or more is pre-biased by 3 before the shift.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);

   // 4-bit wraparound add; no carry ever reaches the neighbouring digit.
   assign o_digit = (i_digit >= adj_thresh()) ? (i_digit + adj_const()) : i_digit;

endmodule

// File: rtl/bcd_seq_ctrl.sv
// Sequential double-dabble converter: one adjust-and-shift step per clock,
// with a registered BCD result and leading-zero blank mask.
module bcd_seq_ctrl
   import bcd_pkg::*;
#(
   parameter int WIDTH  = BCD_WIDTH,
   parameter int DIGITS = BCD_DIGITS,
   parameter int CW     = 5
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  START,
   input  logic [WIDTH-1:0]      BIN,
   output logic                  READY,
   output logic                  DONE,
   output logic [4*DIGITS-1:0]   BCD,
   output logic [DIGITS-1:0]     BLANK
);

   localparam logic [CW-1:0]     LAST_CNT    = CW'(WIDTH - 1);
   localparam logic [DIGITS-1:0] RESET_BLANK = {{(DIGITS-1){1'b1}}, 1'b0};

   state_t                r_state;
   logic                  r_ready;
   logic                  r_done;
   logic [4*DIGITS-1:0]   r_bcd;
   logic [DIGITS-1:0]     r_blank;
   logic [WIDTH-1:0]      r_shift;
   logic [4*DIGITS-1:0]   r_work;
   logic [CW-1:0]         r_cnt;

   logic [4*DIGITS-1:0]   w_adj;
   logic [4*DIGITS-1:0]   w_work_nx;
   logic [WIDTH-1:0]      w_shift_nx;
   logic [DIGITS-1:0]     w_blank;

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_adj
         bcd_digit_adj u_adj (
            .i_digit (r_work[4*g +: 4]),
            .o_digit (w_adj[4*g +: 4])
         );
      end
   endgenerate

   // The adjusted work digits and the binary shift register move as one long word.
   assign {w_work_nx, w_shift_nx} = {w_adj, r_shift} << 1;

   always_comb begin
      logic v_hi_zero;
      w_blank   = '0;
      v_hi_zero = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         v_hi_zero  = v_hi_zero & (w_work_nx[4*i +: 4] == 4'd0);
         w_blank[i] = v_hi_zero;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state <= IDLE;
         r_ready <= 1'b1;
         r_done  <= 1'b0;
         r_bcd   <= '0;
         r_blank <= RESET_BLANK;
         r_shift <= '0;
         r_work  <= '0;
         r_cnt   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (START) begin
                  r_shift <= BIN;
                  r_work  <= '0;
                  r_cnt   <= '0;
                  r_ready <= 1'b0;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               r_work  <= w_work_nx;
               r_shift <= w_shift_nx;
               r_cnt   <= r_cnt + CW'(1);
               if (r_cnt == LAST_CNT) begin
                  r_bcd   <= w_work_nx;
                  r_blank <= w_blank;
                  r_done  <= 1'b1;
                  r_ready <= 1'b1;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_ready <= 1'b1;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign READY = r_ready;
   assign DONE  = r_done;
   assign BCD   = r_bcd;
   assign BLANK = r_blank;

endmodule

// File: tb/tb_bcd_seq_ctrl.sv
// Bench for bcd_seq_ctrl: directed conversions plus a random sweep, checked by a
// DONE-driven monitor against a queue of expected {BCD, BLANK} pairs.
module tb_bcd_seq_ctrl;

   localparam int W  = 18;
   localparam int D  = 6;
   localparam int BW = 4 * D;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [W-1:0]  bin   = '0;
   logic          ready;
   logic          done;
   logic [BW-1:0] bcd;
   logic [D-1:0]  blank;

   logic [BW+D-1:0] exp_q[$];
   logic [BW+D-1:0] mon_e;
   logic            prev_done = 1'b0;
   logic            mon_bad;
   int              checks   = 0;
   int              errors   = 0;
   int              done_cnt = 0;
   int              n_issued = 0;

   always #5 clk = ~clk;

   bcd_seq_ctrl #(.WIDTH(W), .DIGITS(D), .CW(5)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .START (start),
      .BIN   (bin),
      .READY (ready),
      .DONE  (done),
      .BCD   (bcd),
      .BLANK (blank)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [BW-1:0] ref_bcd(input logic [W-1:0] v);
      int unsigned   x;
      logic [BW-1:0] r;
      x = v;
      r = '0;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [D-1:0] ref_blank(input logic [BW-1:0] b);
      logic [D-1:0] r;
      r = '0;
      for (int i = 1; i < D; i++) begin
         r[i] = 1'b1;
         for (int j = i; j < D; j++)
            if (b[4*j +: 4] != 4'd0) r[i] = 1'b0;
      end
      return r;
   endfunction

   // Monitor: every DONE pulse consumes exactly one expectation.
   always @(negedge clk) begin
      if (rst_n && done) begin
         done_cnt++;
         check("done_one_cycle", {63'd0, prev_done}, 64'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("bcd", {40'd0, bcd}, {40'd0, mon_e[BW+D-1:D]});
            check("blank", {58'd0, blank}, {58'd0, mon_e[D-1:0]});
            mon_bad = 1'b0;
            for (int i = 0; i < D; i++)
               if (bcd[4*i +: 4] > 4'd9) mon_bad = 1'b1;
            check("digit_le9", {63'd0, mon_bad}, 64'd0);
         end
      end
      prev_done = done;
   end

   task automatic issue(input logic [W-1:0] v, input logic [BW-1:0] eb, input logic [D-1:0] ebl);
      int t = 0;
      while (!ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("ready_timeout", {63'd0, t >= 100}, 64'd0);
      start = 1'b1;
      bin   = v;
      exp_q.push_back({eb, ebl});
      n_issued++;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic issue_ref(input logic [W-1:0] v);
      logic [BW-1:0] b;
      b = ref_bcd(v);
      issue(v, b, ref_blank(b));
   endtask

   task automatic wait_idle();
      int t = 0;
      while (done_cnt < n_issued && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("done_timeout", {63'd0, done_cnt >= n_issued}, 64'd1);
   endtask

   task automatic count_busy();
      int low = 0;
      @(negedge clk);
      while (!ready && low < 40) begin
         low++;
         @(negedge clk);
      end
      check("ready_low_cycles", 64'(low), 64'd18);
      check("done_with_ready", {63'd0, done}, 64'd1);
   endtask

   initial begin
      int t;
      int snap;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", {63'd0, ready}, 64'd1);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_bcd", {40'd0, bcd}, 64'd0);
      check("rst_blank", {58'd0, blank}, 64'b111110);
      rst_n = 1'b1;
      @(negedge clk);

      issue(18'd0, 24'h000000, 6'b111110);
      wait_idle();

      issue(18'd262143, 24'h262143, 6'b000000);
      count_busy();
      wait_idle();

      // BIN moves right after acceptance; the result must still be 12345.
      issue(18'd12345, 24'h012345, 6'b100000);
      bin = 18'd999;
      wait_idle();

      issue(18'd4096, 24'h004096, 6'b110000);
      repeat (5) @(negedge clk);
      start = 1'b1;
      bin   = 18'd77;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      snap = done_cnt;
      repeat (25) @(negedge clk);
      check("single_done", 64'(done_cnt), 64'(snap));

      // Back-to-back: the next START lands in the DONE cycle.
      issue(18'd65535, 24'h065535, 6'b100000);
      t = 0;
      while (!done && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("b2b_done_seen", {63'd0, done}, 64'd1);
      issue(18'd7, 24'h000007, 6'b111110);
      check("b2b_accepted", {63'd0, ready}, 64'd0);
      wait_idle();

      // Reset partway through a conversion discards it.
      @(negedge clk);
      issue(18'd999, 24'h000999, 6'b111000);
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      n_issued--;
      snap = done_cnt;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_ready", {63'd0, ready}, 64'd1);
      check("abort_done", {63'd0, done}, 64'd0);
      check("abort_bcd", {40'd0, bcd}, 64'd0);
      check("abort_blank", {58'd0, blank}, 64'b111110);
      repeat (25) @(negedge clk);
      check("abort_no_done", 64'(done_cnt), 64'(snap));
      issue(18'd999, 24'h000999, 6'b111000);
      wait_idle();

      for (int i = 0; i < 1000; i++)
         issue_ref(18'($urandom_range(0, (1 << W) - 1)));
      wait_idle();
      repeat (3) @(negedge clk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
